// File: rtl/lsu_pkg.sv
// Shared types for the data load/store unit: access-size codes and FSM states.
package lsu_pkg;

    typedef enum logic [2:0] {
        LSU_B  = 3'b000,
        LSU_H  = 3'b001,
        LSU_W  = 3'b010,
        LSU_BU = 3'b100,
        LSU_HU = 3'b101
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RESP  = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Lane selection for sub-word accesses: load extraction/extension, store merge
// into the current RAM word, and alignment checking.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] mem_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_val,
    output logic [31:0] store_word,
    output logic        misaligned
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = mem_word[{addr_lo, 3'b000} +: 8];
        half_lane = mem_word[{addr_lo[1], 4'b0000} +: 16];

        load_val = mem_word;
        case (size)
            LSU_B:   load_val = {{24{byte_lane[7]}}, byte_lane};
            LSU_BU:  load_val = {24'd0, byte_lane};
            LSU_H:   load_val = {{16{half_lane[15]}}, half_lane};
            LSU_HU:  load_val = {16'd0, half_lane};
            default: load_val = mem_word;
        endcase

        // Sub-word stores keep the untouched lanes of the word just read.
        store_word = store_data;
        case (size)
            LSU_B: begin
                store_word = mem_word;
                store_word[{addr_lo, 3'b000} +: 8] = store_data[7:0];
            end
            LSU_H: begin
                store_word = mem_word;
                store_word[{addr_lo[1], 4'b0000} +: 16] = store_data[15:0];
            end
            default: store_word = store_data;
        endcase

        misaligned = 1'b0;
        if ((size == LSU_H || size == LSU_HU) && addr_lo[0])
            misaligned = 1'b1;
        if (size == LSU_W && addr_lo != 2'b00)
            misaligned = 1'b1;
    end

endmodule

// File: rtl/data_lsu.sv
// Load/store unit between the core memory stage and a word-addressed RAM with
// asynchronous read and synchronous whole-word write.
module data_lsu
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             core_req,
    input  logic             core_we,
    input  logic [2:0]       core_size,
    input  logic [WIDTH-1:0] core_addr,
    input  logic [WIDTH-1:0] core_wd,
    output logic [WIDTH-1:0] core_rd,
    output logic             core_stall,
    output logic             core_err,
    output logic [WIDTH-1:0] mem_a,
    output logic [WIDTH-1:0] mem_wd,
    output logic             mem_we,
    input  logic [WIDTH-1:0] mem_rd
);

    lsu_state_e       state;
    logic [WIDTH-1:0] rd_q;
    logic [WIDTH-1:0] wd_q;
    logic [WIDTH-1:0] addr_q;

    logic [WIDTH-1:0] aligned_addr;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] store_word;
    logic             misaligned;
    logic             bad_code;
    logic             bad_store;
    logic             out_of_range;
    logic             legal;
    logic             req_idle;

    lsu_align u_align (
        .size       (core_size),
        .addr_lo    (core_addr[1:0]),
        .mem_word   (mem_rd),
        .store_data (core_wd),
        .load_val   (load_val),
        .store_word (store_word),
        .misaligned (misaligned)
    );

    always_comb begin
        aligned_addr = {core_addr[WIDTH-1:2], 2'b00};
        bad_code     = core_size inside {3'b011, 3'b110, 3'b111};
        bad_store    = core_we && (core_size == LSU_BU || core_size == LSU_HU);
        out_of_range = core_addr[WIDTH-1:2] >= (WIDTH-2)'(DEPTH);
        legal        = !(bad_code || bad_store || misaligned || out_of_range);

        // Gating with rst_n keeps the handshake quiet while reset is held.
        req_idle   = rst_n && (state == IDLE) && core_req;
        core_stall = req_idle && legal;
        core_err   = req_idle && !legal;

        mem_a = '0;
        if (state == WRITE)
            mem_a = addr_q;
        else if (core_stall)
            mem_a = aligned_addr;

        mem_we = (state == WRITE);
        mem_wd = (state == WRITE) ? wd_q : '0;
    end

    assign core_rd = rd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rd_q   <= '0;
            wd_q   <= '0;
            addr_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (core_req && legal) begin
                        if (core_we) begin
                            wd_q   <= store_word;
                            addr_q <= aligned_addr;
                            state  <= WRITE;
                        end else begin
                            rd_q  <= load_val;
                            state <= RESP;
                        end
                    end
                end
                WRITE:   state <= IDLE;
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_lsu.sv
// Bench for data_lsu: a RAM model on the memory port, directed scenarios and a
// randomized run checked against a word-array reference of the access rules.
module tb_data_lsu;

    logic        clk;
    logic        rst_n;
    logic        core_req;
    logic        core_we;
    logic [2:0]  core_size;
    logic [31:0] core_addr;
    logic [31:0] core_wd;
    logic [31:0] core_rd;
    logic        core_stall;
    logic        core_err;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    logic [31:0] ram     [0:255];
    logic [31:0] ref_mem [0:255];
    logic [31:0] ref_rd;

    int n_checks;
    int n_pass;

    typedef struct {
        logic        s1_stall, s1_err, s1_we;
        logic [31:0] s1_a, s1_rd;
        logic        s2_stall, s2_we;
        logic [31:0] s2_a, s2_wd, s2_rd;
        time         t1, t2;
    } obs_t;

    data_lsu #(.WIDTH(32), .DEPTH(256)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_size  (core_size),
        .core_addr  (core_addr),
        .core_wd    (core_wd),
        .core_rd    (core_rd),
        .core_stall (core_stall),
        .core_err   (core_err),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_we     (mem_we),
        .mem_rd     (mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = (mem_a[31:10] == 22'd0) ? ram[mem_a[9:2]] : 32'd0;

    always @(posedge clk)
        if (mem_we && mem_a[31:10] == 22'd0)
            ram[mem_a[9:2]] <= mem_wd;

    // Reference rules, written directly from the access definitions.
    function automatic bit model_legal(input logic we, input logic [2:0] sz, input logic [31:0] a);
        if (sz == 3 || sz == 6 || sz == 7) return 0;
        if (we && (sz == 4 || sz == 5)) return 0;
        if ((sz == 1 || sz == 5) && (a % 2) != 0) return 0;
        if (sz == 2 && (a % 4) != 0) return 0;
        if ((a / 4) >= 256) return 0;
        return 1;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] sz, input logic [31:0] a);
        logic [31:0] word, v;
        int sh;
        word = ref_mem[(a / 4) % 256];
        sh   = (a % 4) * 8;
        v    = word;
        case (sz)
            3'd0: begin v = (word >> sh) & 32'hFF;   if (v >= 128)   v = v | 32'hFFFF_FF00; end
            3'd4: v = (word >> sh) & 32'hFF;
            3'd1: begin v = (word >> sh) & 32'hFFFF; if (v >= 32768) v = v | 32'hFFFF_0000; end
            3'd5: v = (word >> sh) & 32'hFFFF;
            default: v = word;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] word, mask;
        int sh;
        word = ref_mem[(a / 4) % 256];
        sh   = (a % 4) * 8;
        mask = (sz == 0) ? 32'hFF : (sz == 1) ? 32'hFFFF : 32'hFFFF_FFFF;
        return (word & ~(mask << sh)) | ((wd & mask) << sh);
    endfunction

    task automatic model_apply(input logic we, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
        if (model_legal(we, sz, a)) begin
            if (we) ref_mem[(a / 4) % 256] = model_store(sz, a, wd);
            else    ref_rd = model_load(sz, a);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        ram[idx]     = val;
        ref_mem[idx] = val;
    endtask

    // Drive one request and capture the DUT outputs of each cycle it occupies.
    task automatic issue(input logic we, input logic [2:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, output obs_t o);
        @(negedge clk);
        core_req = 1'b1; core_we = we; core_size = sz; core_addr = a; core_wd = wd;
        #1;
        o.t1 = $time;
        o.s1_stall = core_stall; o.s1_err = core_err; o.s1_we = mem_we;
        o.s1_a = mem_a; o.s1_rd = core_rd;
        o.s2_stall = 1'b0; o.s2_we = 1'b0; o.s2_a = '0; o.s2_wd = '0; o.s2_rd = '0; o.t2 = o.t1;
        if (core_stall) begin
            @(negedge clk);
            #1;
            o.t2 = $time;
            o.s2_stall = core_stall; o.s2_we = mem_we; o.s2_a = mem_a;
            o.s2_wd = mem_wd; o.s2_rd = core_rd;
        end
        $display("txn we=%0d size=%0d addr=%08h wd=%08h stall=%0d err=%0d mem_wd=%08h rd=%08h",
                 we, sz, a, wd, o.s1_stall, o.s1_err, o.s2_wd, o.s2_rd);
        model_apply(we, sz, a, wd);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        core_req = 1'b1; core_we = 1'b1; core_size = 3'd2; core_addr = 32'h10; core_wd = 32'h1234;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (core_rd !== 32'd0) $display("FAIL reset_rd got=%08h exp=00000000", core_rd); else n_pass++;
        n_checks++; if (core_stall !== 1'b0) $display("FAIL reset_stall got=%0d exp=0", core_stall); else n_pass++;
        n_checks++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we got=%0d exp=0", mem_we); else n_pass++;
        n_checks++; if (mem_wd !== 32'd0) $display("FAIL reset_mem_wd got=%08h exp=0", mem_wd); else n_pass++;
        core_size = 3'd3;
        #1;
        n_checks++; if (core_err !== 1'b0) $display("FAIL reset_err got=%0d exp=0", core_err); else n_pass++;
        @(negedge clk);
        core_req = 1'b0;
        rst_n = 1'b1;
        #1;
        n_checks++; if (mem_a !== 32'd0) $display("FAIL idle_mem_a got=%08h exp=0", mem_a); else n_pass++;
    endtask

    task automatic test_word;
        obs_t o;
        issue(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, o);
        n_checks++; if (o.s1_stall !== 1'b1) $display("FAIL sw_stall got=%0d exp=1", o.s1_stall); else n_pass++;
        n_checks++; if (o.s1_we !== 1'b0) $display("FAIL sw_we_c1 got=%0d exp=0", o.s1_we); else n_pass++;
        n_checks++; if (o.s2_we !== 1'b1) $display("FAIL sw_we_c2 got=%0d exp=1", o.s2_we); else n_pass++;
        n_checks++; if (o.s2_stall !== 1'b0) $display("FAIL sw_stall_c2 got=%0d exp=0", o.s2_stall); else n_pass++;
        n_checks++; if (o.s2_a !== 32'h10) $display("FAIL sw_mem_a got=%08h exp=00000010", o.s2_a); else n_pass++;
        n_checks++; if (o.s2_wd !== 32'hDEADBEEF) $display("FAIL sw_mem_wd got=%08h exp=deadbeef", o.s2_wd); else n_pass++;
        issue(1'b0, 3'd2, 32'h10, 32'h0, o);
        n_checks++; if (o.s1_a !== 32'h10) $display("FAIL lw_mem_a got=%08h exp=00000010", o.s1_a); else n_pass++;
        n_checks++; if (o.s2_rd !== 32'hDEADBEEF) $display("FAIL lw_rd got=%08h exp=deadbeef", o.s2_rd); else n_pass++;
    endtask

    task automatic test_byte_rmw;
        obs_t o;
        @(negedge clk); core_req = 1'b0;
        preload(8, 32'h11223344);
        issue(1'b1, 3'd0, 32'h21, 32'hFFFF_FFAA, o);
        n_checks++; if (o.s2_wd !== 32'h1122AA44) $display("FAIL sb_mem_wd got=%08h exp=1122aa44", o.s2_wd); else n_pass++;
        n_checks++; if (o.s2_a !== 32'h20) $display("FAIL sb_mem_a got=%08h exp=00000020", o.s2_a); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (ram[8] !== 32'h1122AA44) $display("FAIL sb_ram got=%08h exp=1122aa44", ram[8]); else n_pass++;
    endtask

    task automatic test_extension;
        obs_t o;
        logic [2:0]  sizes [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
        logic [31:0] addrs [4] = '{32'h30, 32'h33, 32'h32, 32'h30};
        logic [31:0] exps  [4] = '{32'hFFFFFF81, 32'h00000080, 32'hFFFF80F0, 32'h00007F81};
        @(negedge clk); core_req = 1'b0;
        preload(12, 32'h80F07F81);
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, sizes[i], addrs[i], 32'h0, o);
            n_checks++;
            if (o.s2_rd !== exps[i])
                $display("FAIL ext_%0d got=%08h exp=%08h", i, o.s2_rd, exps[i]);
            else n_pass++;
        end
    endtask

    task automatic test_illegal;
        obs_t o;
        logic        wes   [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [2:0]  sizes [5] = '{3'd2, 3'd1, 3'd2, 3'd4, 3'd3};
        logic [31:0] addrs [5] = '{32'h12, 32'h05, 32'h400, 32'h20, 32'h10};
        logic [31:0] keep1, keep8;
        keep1 = ram[1];
        keep8 = ram[8];
        for (int i = 0; i < 5; i++) begin
            issue(wes[i], sizes[i], addrs[i], 32'hCAFE_F00D, o);
            n_checks++; if (o.s1_err !== 1'b1) $display("FAIL ill_%0d_err got=%0d exp=1", i, o.s1_err); else n_pass++;
            n_checks++; if (o.s1_stall !== 1'b0) $display("FAIL ill_%0d_stall got=%0d exp=0", i, o.s1_stall); else n_pass++;
            n_checks++; if (o.s1_we !== 1'b0) $display("FAIL ill_%0d_we got=%0d exp=0", i, o.s1_we); else n_pass++;
            n_checks++; if (o.s1_rd !== ref_rd) $display("FAIL ill_%0d_rd got=%08h exp=%08h", i, o.s1_rd, ref_rd); else n_pass++;
            @(negedge clk); core_req = 1'b0; #1;
            n_checks++; if (core_err !== 1'b0) $display("FAIL ill_%0d_pulse got=%0d exp=0", i, core_err); else n_pass++;
        end
        n_checks++; if (ram[1] !== keep1) $display("FAIL ill_nowrite1 got=%08h exp=%08h", ram[1], keep1); else n_pass++;
        n_checks++; if (ram[8] !== keep8) $display("FAIL ill_nowrite8 got=%08h exp=%08h", ram[8], keep8); else n_pass++;
    endtask

    task automatic test_back_to_back;
        obs_t o1, o2;
        issue(1'b1, 3'd2, 32'h40, 32'h1, o1);
        issue(1'b0, 3'd2, 32'h40, 32'h0, o2);
        n_checks++; if (o2.s2_rd !== 32'h1) $display("FAIL b2b_rd got=%08h exp=00000001", o2.s2_rd); else n_pass++;
        n_checks++;
        if (o2.t2 - o1.t1 !== 30)
            $display("FAIL b2b_span got=%0d exp=30 (ns from first to fourth cycle)", o2.t2 - o1.t1);
        else n_pass++;
    endtask

    task automatic test_random;
        obs_t o;
        logic        we, legal;
        logic [2:0]  sz;
        logic [31:0] a, wd, exp_w, exp_r;
        int          bad;
        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom_range(0, 1));
            sz = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) a = (32'd256 + $urandom_range(0, 1000)) * 4 + $urandom_range(0, 3);
            else                           a = $urandom_range(0, 63) * 4 + $urandom_range(0, 3);
            wd    = $urandom;
            legal = model_legal(we, sz, a);
            exp_w = model_store(sz, a, wd);
            exp_r = model_load(sz, a);
            issue(we, sz, a, wd, o);
            n_checks++;
            if (o.s1_stall !== legal || o.s1_err !== !legal)
                $display("FAIL rnd_%0d_hs got=stall%0d/err%0d exp=stall%0d/err%0d", i, o.s1_stall, o.s1_err, legal, !legal);
            else n_pass++;
            if (legal && we) begin
                n_checks++;
                if (o.s2_we !== 1'b1 || o.s2_a !== {a[31:2], 2'b00} || o.s2_wd !== exp_w)
                    $display("FAIL rnd_%0d_store got=we%0d a=%08h wd=%08h exp=we1 a=%08h wd=%08h",
                             i, o.s2_we, o.s2_a, o.s2_wd, {a[31:2], 2'b00}, exp_w);
                else n_pass++;
            end else if (legal) begin
                n_checks++;
                if (o.s2_rd !== exp_r) $display("FAIL rnd_%0d_load got=%08h exp=%08h", i, o.s2_rd, exp_r);
                else n_pass++;
            end else begin
                n_checks++;
                if (o.s1_rd !== ref_rd) $display("FAIL rnd_%0d_hold got=%08h exp=%08h", i, o.s1_rd, ref_rd);
                else n_pass++;
            end
        end
        @(posedge clk); #1;
        bad = 0;
        for (int k = 0; k < 256; k++) if (ram[k] !== ref_mem[k]) bad++;
        n_checks++; if (bad != 0) $display("FAIL rnd_ram got=%0d differing words exp=0", bad); else n_pass++;
    endtask

    task automatic test_async_reset;
        obs_t o;
        issue(1'b0, 3'd2, 32'h10, 32'h0, o);
        @(negedge clk); core_req = 1'b0;
        preload(20, 32'h0BADC0DE);
        @(negedge clk);
        core_req = 1'b1; core_we = 1'b1; core_size = 3'd2; core_addr = 32'h50; core_wd = 32'h55;
        #1;
        n_checks++; if (core_stall !== 1'b1) $display("FAIL ar_stall got=%0d exp=1", core_stall); else n_pass++;
        @(negedge clk); #1;
        n_checks++; if (mem_we !== 1'b1) $display("FAIL ar_write_cycle got=%0d exp=1", mem_we); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (mem_we !== 1'b0) $display("FAIL ar_we_drop got=%0d exp=0", mem_we); else n_pass++;
        n_checks++; if (core_rd !== 32'd0) $display("FAIL ar_rd got=%08h exp=0", core_rd); else n_pass++;
        core_req = 1'b0;
        ref_rd = 32'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (ram[20] !== 32'h0BADC0DE) $display("FAIL ar_ram got=%08h exp=0badc0de", ram[20]); else n_pass++;
        n_checks++; if (core_rd !== 32'd0) $display("FAIL ar_rd_after got=%08h exp=0", core_rd); else n_pass++;
        issue(1'b0, 3'd2, 32'h50, 32'h0, o);
        n_checks++; if (o.s2_rd !== 32'h0BADC0DE) $display("FAIL ar_reload got=%08h exp=0badc0de", o.s2_rd); else n_pass++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        core_req = 1'b0; core_we = 1'b0; core_size = 3'd0; core_addr = '0; core_wd = '0;
        n_checks = 0;
        n_pass = 0;
        ref_rd = 32'd0;
        for (int k = 0; k < 256; k++) preload(k, $urandom);
        test_reset;
        test_word;
        test_byte_rmw;
        test_extension;
        test_illegal;
        test_back_to_back;
        test_random;
        test_async_reset;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/data_lsu.md
Name: data_lsu

Overview:
- Load/store unit: the initiator side of the data-memory port. It sits between the core's memory stage and the word-addressed data RAM.
- The RAM has an asynchronous read and a synchronous, whole-word write.
- The unit converts byte, halfword and word loads and stores into whole-word RAM accesses, using read-modify-write for sub-word stores.
- It sign- or zero-extends load data, flags illegal accesses, and stalls the core for the multi-cycle sequence.

Parameters:
- WIDTH, 32, data and address width.
- DEPTH, 256, RAM depth in words. Word index = addr[31:2]; legal when < DEPTH.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- core_req  in  1  access request; the core holds it and all other core_* inputs stable while core_stall=1
- core_we  in  1  1=store, 0=load
- core_size  in  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU
- core_addr  in  WIDTH  byte address
- core_wd  in  WIDTH  store data; B/H use the low bits
- core_rd  out  WIDTH  load result, registered
- core_stall  out  1  stall request to the core
- core_err  out  1  one-cycle pulse flagging an illegal access
- mem_a  out  WIDTH  RAM byte address, always word-aligned (bits [1:0]=0)
- mem_wd  out  WIDTH  RAM write data
- mem_we  out  1  RAM write enable
- mem_rd  in  WIDTH  RAM read data, combinational from mem_a

Behaviour:
- FSM states: IDLE, WRITE, RESP. Reset state is IDLE.
- Reset values: core_rd=0, rd_q=0, wd_q=0, addr_q=0. core_err, mem_we and core_stall are all 0 while reset is held.
- Legality check (combinational, evaluated in IDLE), in priority order:
  - size code 011/110/111 is illegal;
  - a store with size 100/101 is illegal;
  - H/HU with addr[0]=1 is misaligned;
  - W with addr[1:0]!=00 is misaligned;
  - addr[31:2] >= DEPTH is out of range.
- IDLE, core_req=0: mem_a=0, mem_we=0, core_stall=0. Stay in IDLE.
- IDLE, core_req=1, illegal access:
  - core_err=1 for this cycle; core_stall=0; no RAM write; core_rd unchanged.
  - Stay in IDLE.
- IDLE, core_req=1, legal load:
  - mem_a={addr[31:2],2'b00}; core_stall=1.
  - At the clock edge, rd_q <= the lane of mem_rd selected by addr[1:0] (B) or addr[1] (H), extended:
    - B/H sign-extend from bit 7/15;
    - BU/HU zero-extend;
    - W passes the word through.
  - Next state RESP.
- IDLE, core_req=1, legal store:
  - mem_a=aligned address; core_stall=1; mem_we=0.
  - At the clock edge, wd_q <= mem_rd with the target lane replaced by core_wd[7:0] or [15:0]. W stores take core_wd whole.
  - addr_q <= the aligned address. Next state WRITE.
- WRITE:
  - mem_a=addr_q, mem_wd=wd_q, mem_we=1, core_stall=0.
  - Next state IDLE. core_req is ignored in this state (same instruction retiring).
- RESP:
  - core_rd=rd_q (core_rd is rd_q, held until the next load completes); core_stall=0.
  - Next state IDLE. core_req is ignored.
- Latency: every legal access takes exactly 2 cycles, with stall high for the first. An illegal access takes 1 cycle.
- mem_we is high only in WRITE. mem_wd=0 outside WRITE.
- Back-to-back accesses: the next request is evaluated in the IDLE cycle after WRITE/RESP. A load following a store therefore reads the updated word.
- Reset mid-operation: reset asserted in WRITE drops mem_we immediately and the store is lost. Reset in RESP returns the FSM to IDLE with core_rd=0.

Decomposition:
- Package lsu_pkg:
  - size enum (LSU_B=3'b000, LSU_H=001, LSU_W=010, LSU_BU=100, LSU_HU=101);
  - FSM state enum (IDLE, WRITE, RESP).
- Sub-module lsu_align (combinational):
  - inputs: size, addr[1:0], mem word, store data;
  - outputs: extended load value, merged store word, misaligned flag.
- data_lsu holds the FSM and the registers.

Test Plan:
- Word store then load:
  - SW addr 0x10, wd 0xDEADBEEF → stall 1 cycle, then mem_we=1 with mem_a=0x10, mem_wd=0xDEADBEEF;
  - LW 0x10 → core_rd=0xDEADBEEF in the second cycle.
- Byte read-modify-write: RAM[0x20]=0x11223344; SB addr 0x21, wd 0xAA → mem_wd=0x1122AA44, written in the WRITE cycle.
- Sign/zero extension on RAM[0x30]=0x80F07F81:
  - LB 0x30 → 0xFFFFFF81;
  - LBU 0x33 → 0x00000080;
  - LH 0x32 → 0xFFFF80F0;
  - LHU 0x30 → 0x00007F81.
- Illegal accesses:
  - LW 0x12 → core_err=1 for 1 cycle, no stall, core_rd unchanged;
  - SH 0x05 → core_err=1, no write;
  - SW 0x400 (index 256, DEPTH=256) → core_err=1, no write;
  - store with size 100 → core_err=1.
- Back-to-back: SW 0x40 0x1 immediately followed by LW 0x40 → core_rd=0x00000001; the total sequence is 4 cycles.
- Asynchronous reset: rst_n low during WRITE of SW 0x50 0x55 → mem_we falls without waiting for a clock edge; after reset, RAM[0x50] still holds its old value and core_rd=0.
